// File: rtl/j1_pstack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | j1_pstack : J1-style parameter stack with registered top and circular     |
// |             array for the entries below it; depth and sticky error flags. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module j1_pstack #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic                     clk,
   input  logic                     resetq,
   input  logic [1:0]               delta,
   input  logic                     we,
   input  logic [WIDTH-1:0]         din,
   input  logic                     clr_err,
   output logic [WIDTH-1:0]         top,
   output logic [WIDTH-1:0]         next,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam int                CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 2);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] top_q, top_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] depth_q, depth_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic [WIDTH-1:0] mem_q [0:DEPTH-2];

   logic             is_push, is_pop, is_full, is_empty;
   logic             push_err, pop_err, mem_we;
   logic [PTR_W-1:0] ptr_inc, ptr_dec;
   logic [WIDTH-1:0] next_w;

   assign next_w = mem_q[ptr_q];

   always_comb begin
      is_push  = (delta == 2'b01);
      is_pop   = (delta == 2'b11);
      is_full  = (depth_q == CNT_FULL);
      is_empty = (depth_q == '0);
      push_err = is_push & is_full;
      pop_err  = is_pop & is_empty;
      ptr_inc  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      ptr_dec  = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;

      top_d   = top_q;
      ptr_d   = ptr_q;
      depth_d = depth_q;
      mem_we  = 1'b0;

      // In wrap mode an error still moves the pointer; only the count is pinned.
      if (is_push) begin
         if (!(push_err && SATURATE)) begin
            mem_we = 1'b1;
            ptr_d  = ptr_inc;
            if (we) top_d = din;
            if (!push_err) depth_d = depth_q + 1'b1;
         end
      end else if (is_pop) begin
         if (!(pop_err && SATURATE)) begin
            top_d = we ? din : next_w;
            ptr_d = ptr_dec;
            if (!pop_err) depth_d = depth_q - 1'b1;
         end
      end else if (we) begin
         top_d = din;
      end

      overflow_d  = (overflow_q & ~clr_err) | push_err;
      underflow_d = (underflow_q & ~clr_err) | pop_err;
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         top_q       <= '0;
         ptr_q       <= '0;
         depth_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         top_q       <= top_d;
         ptr_q       <= ptr_d;
         depth_q     <= depth_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is never cleared; a write is dropped while reset is asserted.
   always_ff @(posedge clk) begin
      if (resetq && mem_we) mem_q[ptr_inc] <= top_q;
   end

   assign top       = top_q;
   assign next      = next_w;
   assign depth     = depth_q;
   assign full      = is_full;
   assign empty     = is_empty;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_j1_pstack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_j1_pstack : bench for j1_pstack, wrap and saturating instances side by |
// |                side, table vectors, corner sequences and random traffic.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_j1_pstack;

   localparam int W = 16;
   localparam int D = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         resetq = 1'b0;
   logic [1:0]   delta = 2'b00;
   logic         we = 1'b0;
   logic [W-1:0] din = '0;
   logic         clr_err = 1'b0;

   logic [W-1:0] top_a [2];
   logic [W-1:0] next_a [2];
   logic [2:0]   depth_a [2];
   logic         full_a [2], empty_a [2], ov_a [2], un_a [2];

   j1_pstack #(.WIDTH(W), .DEPTH(D), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .resetq(resetq), .delta(delta), .we(we), .din(din), .clr_err(clr_err),
      .top(top_a[0]), .next(next_a[0]), .depth(depth_a[0]), .full(full_a[0]),
      .empty(empty_a[0]), .overflow(ov_a[0]), .underflow(un_a[0]));

   j1_pstack #(.WIDTH(W), .DEPTH(D), .SATURATE(1'b1)) u_sat (
      .clk(clk), .resetq(resetq), .delta(delta), .we(we), .din(din), .clr_err(clr_err),
      .top(top_a[1]), .next(next_a[1]), .depth(depth_a[1]), .full(full_a[1]),
      .empty(empty_a[1]), .overflow(ov_a[1]), .underflow(un_a[1]));

   int checks = 0;
   int failures = 0;

   // Reference: linear stack of entries below top, index 0 is the oldest.
   logic [W-1:0] m_top [2];
   bit           m_tkn [2];
   int           m_dep [2];
   logic [W-1:0] m_stk [2][D];
   bit           m_skn [2][D];
   bit           m_ov [2], m_un [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model(input int m, input bit r, input logic [1:0] d, input bit w,
                        input logic [W-1:0] x, input bit c);
      bit           push, pop, sat, ov_ev, un_ev, nk;
      logic [W-1:0] nt;
      push = (d == 2'b01);
      pop  = (d == 2'b11);
      sat  = (m == 1);
      nt   = '0;
      nk   = 1'b0;
      if (!r) begin
         m_top[m] = '0; m_tkn[m] = 1'b1; m_dep[m] = 0; m_ov[m] = 1'b0; m_un[m] = 1'b0;
         return;
      end
      ov_ev = push && (m_dep[m] == D);
      un_ev = pop && (m_dep[m] == 0);
      m_ov[m] = (m_ov[m] && !c) || ov_ev;
      m_un[m] = (m_un[m] && !c) || un_ev;
      if (push) begin
         if (!(ov_ev && sat)) begin
            if (m_dep[m] == D) begin
               for (int i = 0; i < D - 2; i++) begin
                  m_stk[m][i] = m_stk[m][i+1];
                  m_skn[m][i] = m_skn[m][i+1];
               end
               m_stk[m][D-2] = m_top[m];
               m_skn[m][D-2] = m_tkn[m];
            end else if (m_dep[m] >= 1) begin
               m_stk[m][m_dep[m]-1] = m_top[m];
               m_skn[m][m_dep[m]-1] = m_tkn[m];
            end
            if (w) begin m_top[m] = x; m_tkn[m] = 1'b1; end
            if (!ov_ev) m_dep[m]++;
         end
      end else if (pop) begin
         if (!(un_ev && sat)) begin
            if (m_dep[m] >= 2) begin
               nt = m_stk[m][m_dep[m]-2];
               nk = m_skn[m][m_dep[m]-2];
            end
            m_top[m] = w ? x : nt;
            m_tkn[m] = w ? 1'b1 : nk;
            if (!un_ev) m_dep[m]--;
         end
      end else if (w) begin
         m_top[m] = x; m_tkn[m] = 1'b1;
      end
   endtask

   task automatic model_checks(input string tag);
      for (int m = 0; m < 2; m++) begin
         if (m_tkn[m]) check($sformatf("%s_m%0d_top", tag, m), 32'(top_a[m]), 32'(m_top[m]));
         if (m_dep[m] >= 2 && m_skn[m][m_dep[m]-2])
            check($sformatf("%s_m%0d_next", tag, m), 32'(next_a[m]), 32'(m_stk[m][m_dep[m]-2]));
         check($sformatf("%s_m%0d_depth", tag, m), 32'(depth_a[m]), 32'(m_dep[m]));
         check($sformatf("%s_m%0d_full", tag, m), 32'(full_a[m]), 32'(m_dep[m] == D));
         check($sformatf("%s_m%0d_empty", tag, m), 32'(empty_a[m]), 32'(m_dep[m] == 0));
         check($sformatf("%s_m%0d_ovf", tag, m), 32'(ov_a[m]), 32'(m_ov[m]));
         check($sformatf("%s_m%0d_unf", tag, m), 32'(un_a[m]), 32'(m_un[m]));
      end
   endtask

   task automatic step(input bit r, input logic [1:0] d, input bit w,
                       input logic [W-1:0] x, input bit c, input string tag);
      resetq = r; delta = d; we = w; din = x; clr_err = c;
      model(0, r, d, w, x, c);
      model(1, r, d, w, x, c);
      @(posedge clk);
      #1;
      model_checks(tag);
   endtask

   // Hand-written expectations for one instance, taken straight from the scenarios.
   task automatic expect_state(input string n, input int m, input int t, input int dep,
                               input bit ov, input bit un);
      check($sformatf("%s_m%0d_top", n, m), 32'(top_a[m]), 32'(t));
      check($sformatf("%s_m%0d_depth", n, m), 32'(depth_a[m]), 32'(dep));
      check($sformatf("%s_m%0d_ovf", n, m), 32'(ov_a[m]), 32'(ov));
      check($sformatf("%s_m%0d_unf", n, m), 32'(un_a[m]), 32'(un));
   endtask

   typedef struct {
      bit           r;
      logic [1:0]   d;
      bit           w;
      logic [W-1:0] x;
      int           e_top;
      int           e_next;
      int           e_dep;
      bit           e_full;
      bit           e_empty;
   } vec_t;

   vec_t vt [8];

   initial begin
      vt[0] = '{1'b0, 2'b00, 1'b0, 16'd0, 0, -1, 0, 1'b0, 1'b1};
      vt[1] = '{1'b1, 2'b01, 1'b1, 16'd1, 1, -1, 1, 1'b0, 1'b0};
      vt[2] = '{1'b1, 2'b01, 1'b1, 16'd2, 2,  1, 2, 1'b0, 1'b0};
      vt[3] = '{1'b1, 2'b01, 1'b1, 16'd3, 3,  2, 3, 1'b0, 1'b0};
      vt[4] = '{1'b1, 2'b01, 1'b1, 16'd4, 4,  3, 4, 1'b1, 1'b0};
      vt[5] = '{1'b1, 2'b11, 1'b0, 16'd0, 3,  2, 3, 1'b0, 1'b0};
      vt[6] = '{1'b1, 2'b11, 1'b0, 16'd0, 2,  1, 2, 1'b0, 1'b0};
      vt[7] = '{1'b1, 2'b11, 1'b0, 16'd0, 1, -1, 1, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         step(vt[i].r, vt[i].d, vt[i].w, vt[i].x, 1'b0, $sformatf("vec%0d", i));
         for (int m = 0; m < 2; m++) begin
            check($sformatf("vec%0d_m%0d_tbl_top", i, m), 32'(top_a[m]), 32'(vt[i].e_top));
            if (vt[i].e_next >= 0)
               check($sformatf("vec%0d_m%0d_tbl_next", i, m), 32'(next_a[m]), 32'(vt[i].e_next));
            check($sformatf("vec%0d_m%0d_tbl_depth", i, m), 32'(depth_a[m]), 32'(vt[i].e_dep));
            check($sformatf("vec%0d_m%0d_tbl_full", i, m), 32'(full_a[m]), 32'(vt[i].e_full));
            check($sformatf("vec%0d_m%0d_tbl_empty", i, m), 32'(empty_a[m]), 32'(vt[i].e_empty));
            check($sformatf("vec%0d_m%0d_tbl_ovf", i, m), 32'(ov_a[m]), 32'(0));
         end
      end

      // Push into a full stack: saturating holds, wrapping overwrites the oldest.
      step(1'b0, 2'b00, 1'b0, 16'd0, 1'b0, "ovf_rst");
      for (int v = 1; v <= 4; v++) step(1'b1, 2'b01, 1'b1, W'(v), 1'b0, "ovf_fill");
      step(1'b1, 2'b01, 1'b1, 16'd5, 1'b0, "ovf_push");
      expect_state("ovf_push", 0, 5, 4, 1'b1, 1'b0);
      expect_state("ovf_push", 1, 4, 4, 1'b1, 1'b0);
      step(1'b1, 2'b00, 1'b0, 16'd0, 1'b1, "ovf_clr");
      expect_state("ovf_clr", 0, 5, 4, 1'b0, 1'b0);
      expect_state("ovf_clr", 1, 4, 4, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 2'b11, 1'b0, 16'd0, 1'b0, "ovf_pop");
         expect_state($sformatf("ovf_pop%0d", k), 0, 4 - k, 3 - k, 1'b0, 1'b0);
         expect_state($sformatf("ovf_pop%0d", k), 1, 3 - k, 3 - k, 1'b0, 1'b0);
      end

      // Pop on empty; a repeated error with clear keeps the flag set.
      step(1'b0, 2'b00, 1'b0, 16'd0, 1'b0, "unf_rst");
      step(1'b1, 2'b11, 1'b0, 16'd0, 1'b0, "unf_pop");
      for (int m = 0; m < 2; m++) begin
         check($sformatf("unf_pop_m%0d_unf", m), 32'(un_a[m]), 32'(1));
         check($sformatf("unf_pop_m%0d_empty", m), 32'(empty_a[m]), 32'(1));
      end
      step(1'b1, 2'b11, 1'b0, 16'd0, 1'b1, "unf_pop_clr");
      for (int m = 0; m < 2; m++) begin
         check($sformatf("unf_clr_m%0d_unf", m), 32'(un_a[m]), 32'(1));
         check($sformatf("unf_clr_m%0d_depth", m), 32'(depth_a[m]), 32'(0));
      end

      // Reset mid-stream with an error pending and depth 3.
      step(1'b0, 2'b00, 1'b0, 16'd0, 1'b0, "mid_rst0");
      for (int v = 1; v <= 5; v++) step(1'b1, 2'b01, 1'b1, W'(v), 1'b0, "mid_fill");
      step(1'b1, 2'b11, 1'b0, 16'd0, 1'b0, "mid_pop");
      for (int m = 0; m < 2; m++) begin
         check($sformatf("mid_pre_m%0d_depth", m), 32'(depth_a[m]), 32'(3));
         check($sformatf("mid_pre_m%0d_ovf", m), 32'(ov_a[m]), 32'(1));
      end
      step(1'b0, 2'b01, 1'b1, 16'hBEEF, 1'b0, "mid_rst");
      for (int m = 0; m < 2; m++) begin
         expect_state("mid_rst", m, 0, 0, 1'b0, 1'b0);
         check($sformatf("mid_rst_m%0d_empty", m), 32'(empty_a[m]), 32'(1));
      end

      // Random traffic against the reference.
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 59) != 0), 2'($urandom), 1'($urandom), W'($urandom),
              ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/j1_pstack.md
J1_PSTACK -- requirements
Module: j1_pstack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the data width of every stack entry.
REQ-002 SHALL have parameter DEPTH, default 32, meaning total capacity including the top register; power of two, >= 4.
REQ-003 SHALL have parameter SATURATE, default 0, meaning the full/empty policy: 0 = circular wrap, 1 = saturating.
REQ-004 SHALL use one clock; reset is synchronous and active-low; ports clk and resetq.
REQ-005 SHALL have port `clk`: input, 1 bit, rising-edge clock.
REQ-006 SHALL have port `resetq`: input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port `delta`: input, 2 bits; 2'b01 = push, 2'b11 = pop, 2'b00 and 2'b10 = no move.
REQ-008 SHALL have port `we`: input, 1 bit, loads din into the top entry.
REQ-009 SHALL have port `din`: input, WIDTH bits, new top value.
REQ-010 SHALL have port `clr_err`: input, 1 bit, clears the sticky error flags.
REQ-011 SHALL have port `top`: output, WIDTH bits, registered top entry (st0).
REQ-012 SHALL have port `next`: output, WIDTH bits, entry directly below top (st1), read from the storage array at the current pointer.
REQ-013 SHALL have port `depth`: output, $clog2(DEPTH)+1 bits, count of valid entries, 0..DEPTH.
REQ-014 SHALL have port `full`: output, 1 bit, asserted when depth == DEPTH (combinational from depth).
REQ-015 SHALL have port `empty`: output, 1 bit, asserted when depth == 0 (combinational from depth).
REQ-016 SHALL have port `overflow`: output, 1 bit, sticky push-when-full flag.
REQ-017 SHALL have port `underflow`: output, 1 bit, sticky pop-when-empty flag.

Function
REQ-018 SHALL store DEPTH entries as one top register plus a circular array of DEPTH-1 entries indexed by a wrapping pointer.
REQ-019 SHALL, on push, write the old top into the array at pointer+1, advance the pointer, set top to din if we=1 and leave top unchanged otherwise (dup), and increment depth.
REQ-020 SHALL, on pop, set top to din if we=1 and to next otherwise, decrement the pointer, and decrement depth.
REQ-021 SHALL, on no move, set top to din if we=1; pointer and depth are unchanged.
REQ-022 SHALL update all registered state on the single rising edge following the request; zero wait states; a new operation is accepted every cycle.
REQ-023 SHALL, when SATURATE=1 and a push arrives while full, set overflow and leave top, pointer, array and depth unchanged.
REQ-024 SHALL, when SATURATE=1 and a pop arrives while empty, set underflow and leave all state unchanged.
REQ-025 SHALL, when SATURATE=0 and a push arrives while full, set overflow, perform the push (oldest entry overwritten by pointer wrap), and hold depth at DEPTH.
REQ-026 SHALL, when SATURATE=0 and a pop arrives while empty, set underflow, perform the pop (top takes the stale next value), and hold depth at 0.
REQ-027 SHALL clear overflow and underflow on clr_err=1; a new error in the same cycle sets its flag, and set wins over clear.
REQ-028 SHALL wrap the pointer modulo DEPTH-1; the array uses a synchronous write and an asynchronous read.
REQ-029 SHALL treat the value of next as unspecified while depth < 2.

Reset
REQ-030 SHALL, while resetq=0 at a rising edge, set top=0, pointer=0, depth=0, overflow=0 and underflow=0 regardless of the other inputs.
REQ-031 SHALL not reset the array contents.
REQ-032 SHALL abandon any in-flight operation when reset is applied mid-sequence.

Verification (WIDTH=16, DEPTH=4)
REQ-033 SHALL cover: reset, then push with we of 1,2,3,4 -> top=4, next=3, depth=4, full=1, overflow=0.
REQ-034 SHALL cover: after REQ-033, three pops with we=0 -> top 3, 2, 1 on successive cycles, then depth=1, empty=0.
REQ-035 SHALL cover: SATURATE=1, full with 1..4, push din=5 -> overflow=1, top=4, depth=4; then clr_err -> overflow=0.
REQ-036 SHALL cover: SATURATE=0, full with 1..4, push din=5 -> overflow=1, top=5, depth=4; then three pops -> top 4, 3, 2.
REQ-037 SHALL cover: pop while empty -> underflow=1, depth=0, empty=1; a repeated pop-on-empty together with clr_err=1 -> underflow stays 1.
REQ-038 SHALL cover: resetq=0 for one cycle after depth=3 with overflow=1 -> top=0, depth=0, empty=1, overflow=0, underflow=0 on the next edge.
